// File: rtl/trigger_capture_pkg.sv
// Shared types and default widths for trigger_phase_capture and its timestamp FIFO.
package trigger_capture_pkg;

  localparam int PHASE_WIDTH_DEF  = 16;
  localparam int PERIOD_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BSYNC = 2'd1,
    RUN        = 2'd2
  } capture_state_t;

  typedef struct packed {
    logic [PERIOD_WIDTH_DEF-1:0] period;
    logic [PHASE_WIDTH_DEF-1:0]  phase;
  } ts_entry_t;

endpackage

// File: rtl/trigger_capture_fifo.sv
// First-word-fall-through FIFO with synchronous flush; a push while full is dropped.
module trigger_capture_fifo
  import trigger_capture_pkg::*;
#(
  parameter type entry_t = ts_entry_t,
  parameter int  DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t din_i,
  output entry_t dout_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign dout_o    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/trigger_phase_capture.sv
// Timestamps trig_in rising edges as {period, phase} on the BSYNC grid.
// Period counter and period field exist only with TRIGGER_CAPTURE_PERIOD_EN defined.
module trigger_phase_capture
  import trigger_capture_pkg::*;
#(
  parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF,
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic                    bsync_ready,
  input  logic                    bsync_event,
  input  logic [PHASE_WIDTH-1:0]  bsync_ratio,
  input  logic                    trig_in,
  output logic                    ts_valid,
  input  logic                    ts_ready,
  output logic [PHASE_WIDTH-1:0]  ts_phase,
  output logic [PERIOD_WIDTH-1:0] ts_period,
  input  logic                    flags_clr,
  output logic                    overflow,
  output logic                    misalign,
  output logic [1:0]              capture_state
);

`ifdef TRIGGER_CAPTURE_PERIOD_EN
  typedef struct packed {
    logic [PERIOD_WIDTH-1:0] period;
    logic [PHASE_WIDTH-1:0]  phase;
  } entry_t;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
`else
  typedef struct packed {
    logic [PHASE_WIDTH-1:0] phase;
  } entry_t;
`endif

  capture_state_t         state_q, state_d;
  logic [PHASE_WIDTH-1:0] ratio_q, ratio_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   trig_q;
  logic                   overflow_q, overflow_d;
  logic                   misalign_q, misalign_d;
  logic                   go_idle_s, in_run_s, last_phase_s, wrap_s, rise_s;
  logic                   push_s, pop_s, fifo_full_s, fifo_empty_s;
  logic                   misalign_set_s, overflow_set_s;
  entry_t                 entry_in_s, entry_out_s;

  assign go_idle_s      = !enable || !bsync_ready;
  assign in_run_s       = (state_q == RUN);
  assign last_phase_s   = (phase_q == ratio_q - PHASE_WIDTH'(1'b1));
  // An off-grid bsync_event realigns exactly like a normal wrap.
  assign wrap_s         = last_phase_s || bsync_event;
  assign rise_s         = trig_in && !trig_q;
  assign push_s         = in_run_s && rise_s;
  assign pop_s          = !fifo_empty_s && ts_ready;
  assign misalign_set_s = in_run_s && bsync_event && !last_phase_s;
  assign overflow_set_s = push_s && fifo_full_s;

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    if (go_idle_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = WAIT_BSYNC;
        WAIT_BSYNC: begin
          if (bsync_event) begin
            state_d = RUN;
            ratio_d = (bsync_ratio == '0) ? PHASE_WIDTH'(1'b1) : bsync_ratio;
          end else begin
            state_d = WAIT_BSYNC;
          end
        end
        RUN:        state_d = RUN;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    phase_d = '0;
`ifdef TRIGGER_CAPTURE_PERIOD_EN
    period_d = '0;
`endif
    if (in_run_s) begin
      phase_d = wrap_s ? '0 : phase_q + PHASE_WIDTH'(1'b1);
`ifdef TRIGGER_CAPTURE_PERIOD_EN
      period_d = wrap_s ? period_q + PERIOD_WIDTH'(1'b1) : period_q;
`endif
    end else begin
      phase_d = '0;
    end
    overflow_d = overflow_set_s || (overflow_q && !flags_clr);
    misalign_d = misalign_set_s || (misalign_q && !flags_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ratio_q    <= PHASE_WIDTH'(1'b1);
      phase_q    <= '0;
`ifdef TRIGGER_CAPTURE_PERIOD_EN
      period_q   <= '0;
`endif
      trig_q     <= 1'b0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      phase_q    <= phase_d;
`ifdef TRIGGER_CAPTURE_PERIOD_EN
      period_q   <= period_d;
`endif
      trig_q     <= trig_in;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    entry_in_s       = '0;
    entry_in_s.phase = phase_q;
`ifdef TRIGGER_CAPTURE_PERIOD_EN
    entry_in_s.period = period_q;
`endif
  end

  trigger_capture_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (go_idle_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (entry_in_s),
    .dout_o  (entry_out_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign ts_valid      = !fifo_empty_s;
  assign ts_phase      = entry_out_s.phase;
`ifdef TRIGGER_CAPTURE_PERIOD_EN
  assign ts_period     = entry_out_s.period;
`else
  assign ts_period     = '0;
`endif
  assign overflow      = overflow_q;
  assign misalign      = misalign_q;
  assign capture_state = state_q;

endmodule
